// File: rtl/ppu_timing_monitor.sv
// ppu_timing_monitor: synchronises PPU1 raster strobes, measures line period and lines per frame,
// and hands out one snapshot per frame over a valid/ready handshake.
module ppu_timing_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CYC_W       = 16,
    parameter int LINE_W      = 10,
    parameter int FRAME_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               ppu1_hcld_n,
    input  logic               ppu1_vcld_n,
    output logic               snap_valid,
    input  logic               snap_ready,
    output logic [CYC_W-1:0]   snap_line_cycles,
    output logic [LINE_W-1:0]  snap_lines,
    output logic [FRAME_W-1:0] snap_frame,
    output logic               locked,
    output logic               overflow
);
    typedef enum logic [1:0] {IDLE, WAIT_V, MEASURE} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] hsync_q, vsync_q;
    logic                 hprev_q, vprev_q;
    logic                 hpulse, vpulse;
    logic [CYC_W-1:0]     cyc_q, cyc_d, period_q, period_d, cyc_inc, snap_cyc_q, snap_cyc_d;
    logic [LINE_W-1:0]    line_q, line_d, snap_lines_q, snap_lines_d;
    logic [FRAME_W-1:0]   frame_q, frame_d, snap_frame_q, snap_frame_d;
    logic                 snap_valid_q, snap_valid_d, locked_q, locked_d, ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= '1;
            vsync_q <= '1;
            hprev_q <= 1'b1;
            vprev_q <= 1'b1;
        end else begin
            hsync_q <= {hsync_q[SYNC_STAGES-2:0], ppu1_hcld_n};
            vsync_q <= {vsync_q[SYNC_STAGES-2:0], ppu1_vcld_n};
            hprev_q <= hsync_q[SYNC_STAGES-1];
            vprev_q <= vsync_q[SYNC_STAGES-1];
        end
    end

    assign hpulse  = hprev_q & ~hsync_q[SYNC_STAGES-1];
    assign vpulse  = vprev_q & ~vsync_q[SYNC_STAGES-1];
    assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        line_d       = line_q;
        period_d     = period_q;
        frame_d      = frame_q;
        snap_valid_d = snap_valid_q;
        snap_cyc_d   = snap_cyc_q;
        snap_lines_d = snap_lines_q;
        snap_frame_d = snap_frame_q;
        locked_d     = locked_q;
        ovf_d        = ovf_q;
        case (state_q)
            IDLE: state_d = WAIT_V;
            WAIT_V: if (vpulse) begin
                state_d = MEASURE;
                line_d  = {{(LINE_W-1){1'b0}}, hpulse};
            end
            MEASURE: begin
                if (hpulse) begin
                    cyc_d    = '0;
                    period_d = cyc_inc;
                    line_d   = (&line_q) ? line_q : line_q + 1'b1;
                    ovf_d    = ovf_q | (&line_q);
                end else begin
                    cyc_d = cyc_inc;
                    ovf_d = ovf_q | (&cyc_q);
                end
                if (snap_valid_q && snap_ready)
                    snap_valid_d = 1'b0;
                // A line ending on the frame strobe is reported with its own period, not the previous one
                if (vpulse) begin
                    line_d   = {{(LINE_W-1){1'b0}}, hpulse};
                    frame_d  = frame_q + 1'b1;
                    locked_d = 1'b1;
                    if (!snap_valid_q || snap_ready) begin
                        snap_valid_d = 1'b1;
                        snap_cyc_d   = hpulse ? cyc_inc : period_q;
                        snap_lines_d = line_q;
                        snap_frame_d = frame_q;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d      = IDLE;
            cyc_d        = '0;
            line_d       = '0;
            period_d     = '0;
            frame_d      = '0;
            snap_valid_d = 1'b0;
            snap_cyc_d   = '0;
            snap_lines_d = '0;
            snap_frame_d = '0;
            locked_d     = 1'b0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            line_q       <= '0;
            period_q     <= '0;
            frame_q      <= '0;
            snap_valid_q <= 1'b0;
            snap_cyc_q   <= '0;
            snap_lines_q <= '0;
            snap_frame_q <= '0;
            locked_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            line_q       <= line_d;
            period_q     <= period_d;
            frame_q      <= frame_d;
            snap_valid_q <= snap_valid_d;
            snap_cyc_q   <= snap_cyc_d;
            snap_lines_q <= snap_lines_d;
            snap_frame_q <= snap_frame_d;
            locked_q     <= locked_d;
            ovf_q        <= ovf_d;
        end
    end

    assign snap_valid       = snap_valid_q;
    assign snap_line_cycles = snap_cyc_q;
    assign snap_lines       = snap_lines_q;
    assign snap_frame       = snap_frame_q;
    assign locked           = locked_q;
    assign overflow         = ovf_q;
endmodule

// File: doc/ppu_timing_monitor.md
Name: ppu_timing_monitor

Overview:
- Receiver for the PPU1 raster timing strobes: ppu1_hcld_n (line start) and ppu1_vcld_n (frame start).
- Synchronises both strobes into the FPGA clock domain, measures line period in clk cycles and lines per frame, and counts frames.
- Delivers one snapshot per frame to the host-facing logic over a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth per strobe input, minimum 2.
- CYC_W, 16: width of the line-period (clk cycles per line) measurement.
- LINE_W, 10: width of the lines-per-frame measurement.
- FRAME_W, 16: width of the frame counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active high.
- enable  input  1  1 = run the monitor; 0 = hold idle and clear state.
- ppu1_hcld_n  input  1  asynchronous active-low line strobe from PPU1.
- ppu1_vcld_n  input  1  asynchronous active-low frame strobe from PPU1.
- snap_valid  output  1  snapshot available.
- snap_ready  input  1  consumer accepts snapshot.
- snap_line_cycles  output  CYC_W  last complete line period, in clk cycles.
- snap_lines  output  LINE_W  number of lines in the last complete frame.
- snap_frame  output  FRAME_W  frame index of the snapshot.
- locked  output  1  at least one complete frame has been measured.
- overflow  output  1  sticky error: a snapshot was dropped or a counter saturated.

Behaviour:
- Reset: all outputs and internal registers are 0. Synchronisers reset to 1 (the inactive level).
- Synchroniser: SYNC_STAGES flops per input, plus one edge-detect register.
  - Falling edge (previous synchronised value 1, current 0) produces a one-cycle internal pulse, hpulse or vpulse.
  - Latency from input fall to pulse: SYNC_STAGES+1 clk cycles.
  - Stuck-low input produces only one pulse.
- FSM states:
  - IDLE: enable=0. All counters, snap_valid, locked and overflow are cleared. Go to WAIT_V when enable=1.
  - WAIT_V: counters held at 0. On vpulse go to MEASURE, with line_cnt=0 and cyc_cnt=0. No snapshot is produced.
  - MEASURE: measurement active, as described below.
  - enable=0 in any state returns to IDLE the next cycle. rst overrides enable.
- cyc_cnt (CYC_W bits): cleared to 0 on hpulse, otherwise increments.
  - On hpulse, line_period <= cyc_cnt+1, saturated at all-ones.
  - If cyc_cnt reaches all-ones it holds there and sets overflow.
- line_cnt (LINE_W bits): increments on hpulse; saturates at all-ones and sets overflow.
- On vpulse in MEASURE:
  - Frame lines are captured as line_cnt; frame_cnt increments, wrapping modulo 2^FRAME_W.
  - locked is set.
  - line_cnt restarts at 0.
- Simultaneous hpulse and vpulse:
  - The vpulse capture uses line_cnt excluding this hpulse.
  - line_cnt then becomes 1.
  - line_period updates normally.
- Snapshot on vpulse in MEASURE:
  - If snap_valid=0, or snap_valid=1 and snap_ready=1 in the same cycle: load snap_line_cycles=line_period, snap_lines=captured lines and snap_frame=frame_cnt (value before increment). snap_valid=1 next cycle.
  - If snap_valid=1 and snap_ready=0: keep the old snapshot unchanged and set overflow (dropped frame).
- Handshake:
  - Transfer occurs when snap_valid and snap_ready are both 1 on a clk edge. snap_valid falls next cycle unless reloaded as above.
  - Snapshot data is stable while snap_valid=1 and snap_ready=0.
  - snap_ready is ignored while snap_valid=0.
- The first vpulse after entering MEASURE is the second vpulse after enable. It yields snap_frame=0.
- overflow is cleared only by rst or by enable=0.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then enable=0 with strobes toggling. Required: all outputs remain 0 and snap_valid never rises.
- Nominal NTSC-like timing (SYNC_STAGES=2):
  - Stimulus: enable=1; hcld pulses every 341 clk; vcld with every 262nd hcld. First vcld enters MEASURE.
  - Required at the next vcld: snap_valid=1, snap_line_cycles=341, snap_lines=262, snap_frame=0, locked=1.
  - Required at the following vcld: snap_frame=1.
- Backpressure: hold snap_ready=0 across 2 frames. Required: first snapshot held unchanged, overflow=1 after the second vcld. Then set ready=1: one transfer occurs, snap_valid drops.
- Simultaneous ready and vcld: assert snap_ready on the same cycle as vpulse. Required: new snapshot loaded, snap_valid stays 1, overflow remains 0.
- Saturation: CYC_W=8, hcld gap of 300 clk. Required: snap_line_cycles=255, overflow=1.
- Mid-operation disable: enable=0 for 1 cycle mid-frame, then 1. Required: IDLE clears everything. The next vcld produces no snapshot; the vcld after that gives snap_frame=0.
